// File: rtl/led_dimmer_pkg.sv
// Shared constants and saturating level arithmetic for the LED PWM dimmer.
// Both the top level and the button debouncer import this package.
package led_dimmer_pkg;

  localparam int DEF_CHANNELS        = 9;
  localparam int DEF_PWM_BITS        = 8;
  localparam int DEF_PRESCALE        = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LEVEL_STEP      = 16;
  localparam int DEF_LEVEL_RESET     = 32;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_UP   = 2'd1,
    LVL_DOWN = 2'd2
  } level_op_e;

  function automatic int level_max(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

  localparam int LEVEL_MAX = level_max(DEF_PWM_BITS);

  // Operands are at most PWM_BITS wide, so 32-bit arithmetic cannot overflow
  // and matches the PWM_BITS+1 intermediate before clamping.
  function automatic int unsigned sat_add(input int unsigned value,
                                          input int unsigned step,
                                          input int unsigned max_value);
    int unsigned sum;
    sum = value + step;
    return (sum > max_value) ? max_value : sum;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned value,
                                          input int unsigned step);
    return (value < step) ? 0 : value - step;
  endfunction

  // Simultaneous presses cancel out.
  function automatic level_op_e decode_level_op(input logic up, input logic down);
    level_op_e op;
    op = LVL_HOLD;
    if (up && !down) op = LVL_UP;
    else if (down && !up) op = LVL_DOWN;
    return op;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, debounce counter that
// accepts a new level after DEBOUNCE_CYCLES disagreeing cycles, and a press pulse.
module button_debounce
  import led_dimmer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_q & ~stable_dly_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_dimmer.sv
// PWM brightness stage: gates the pattern generator's colour channels with a
// shared PWM waveform whose duty is stepped by two debounced push-buttons.
module led_dimmer
  import led_dimmer_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int PWM_BITS        = DEF_PWM_BITS,
  parameter int PRESCALE        = DEF_PRESCALE,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LEVEL_STEP      = DEF_LEVEL_STEP,
  parameter int LEVEL_RESET     = DEF_LEVEL_RESET
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic [CHANNELS-1:0] led_in,
  output logic [CHANNELS-1:0] led_out,
  output logic [PWM_BITS-1:0] level
);

  localparam int PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LVL_MAX = level_max(PWM_BITS);
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] LVL_RESET = PWM_BITS'(LEVEL_RESET);

  logic [PS_W-1:0]     ps_q, ps_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] active_level_q, active_level_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] led_out_q, led_out_d;
  logic                tick;
  logic                period_start;
  logic                gate_open;
  logic                up_press, down_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
    .clock   (clock),
    .reset_  (reset_),
    .btn_i   (btn_up),
    .press_o (up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
    .clock   (clock),
    .reset_  (reset_),
    .btn_i   (btn_down),
    .press_o (down_press)
  );

  assign tick         = (ps_q == PS_LAST);
  assign period_start = tick && (pwm_cnt_q == '1);
  assign gate_open    = (pwm_cnt_q < active_level_q);

  // The duty latched at period start keeps a level change from truncating a period.
  always_comb begin
    ps_d           = tick ? '0 : ps_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    active_level_d = period_start ? level_q : active_level_q;
    led_out_d      = led_in & {CHANNELS{gate_open}};
  end

  always_comb begin
    level_d = level_q;
    case (decode_level_op(up_press, down_press))
      LVL_UP:   level_d = PWM_BITS'(sat_add(32'(level_q), LEVEL_STEP, LVL_MAX));
      LVL_DOWN: level_d = PWM_BITS'(sat_sub(32'(level_q), LEVEL_STEP));
      default:  level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ps_q           <= '0;
      pwm_cnt_q      <= '0;
      active_level_q <= LVL_RESET;
      level_q        <= LVL_RESET;
      led_out_q      <= '0;
    end else begin
      ps_q           <= ps_d;
      pwm_cnt_q      <= pwm_cnt_d;
      active_level_q <= active_level_d;
      level_q        <= level_d;
      led_out_q      <= led_out_d;
    end
  end

  assign led_out = led_out_q;
  assign level   = level_q;

endmodule

// File: tb/tb_led_dimmer.sv
// Directed bench for led_dimmer with PRESCALE=1 and DEBOUNCE_CYCLES=8, so one
// PWM period is 256 cycles and a button press lands 12 cycles after its raw edge.
module tb_led_dimmer;

  localparam int CH = 9;
  localparam int PB = 8;

  logic          clock    = 1'b0;
  logic          reset_   = 1'b1;
  logic          btn_up   = 1'b0;
  logic          btn_down = 1'b0;
  logic [CH-1:0] led_in   = '0;
  logic [CH-1:0] led_out;
  logic [PB-1:0] level;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  led_dimmer #(
    .CHANNELS        (CH),
    .PWM_BITS        (PB),
    .PRESCALE        (1),
    .DEBOUNCE_CYCLES (8),
    .LEVEL_STEP      (16),
    .LEVEL_RESET     (32)
  ) dut (
    .clock    (clock),
    .reset_   (reset_),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .led_in   (led_in),
    .led_out  (led_out),
    .level    (level)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Leaves the bench on a negedge right after release: the next posedge is period cycle 1.
  task automatic do_reset(input logic [CH-1:0] pat);
    @(negedge clock);
    reset_   = 1'b0;
    led_in   = pat;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic press(input logic up, input logic down);
    btn_up   = up;
    btn_down = down;
    repeat (14) @(negedge clock);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (14) @(negedge clock);
  endtask

  // Period-aligned window: led_out must equal pat for the first `high` cycles, then 0.
  task automatic measure_window(input logic [CH-1:0] pat, input int high,
                                output int bad, output int first_k,
                                output logic [CH-1:0] first_val);
    logic [CH-1:0] exp;
    bad       = 0;
    first_k   = 0;
    first_val = '0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clock);
      exp = (k <= high) ? pat : '0;
      if (led_out !== exp) begin
        if (bad == 0) begin
          first_k   = k;
          first_val = led_out;
        end
        bad++;
      end
    end
  endtask

  // Any 256-cycle window with a constant duty: counts cycles showing pat and stray values.
  task automatic count_high(input logic [CH-1:0] pat, output int n_on, output int n_bad);
    n_on  = 0;
    n_bad = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clock);
      if (led_out === pat) n_on++;
      else if (led_out !== '0) n_bad++;
    end
  endtask

  task automatic test_reset();
    int bad, fk;
    logic [CH-1:0] fv;
    led_in = '1;
    #2;
    reset_ = 1'b0;
    #1;
    tests_run++;
    if (led_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_led_out: got %b expected %b", led_out, 9'b0);
    end
    tests_run++;
    if (level !== 8'd32) begin
      tests_failed++;
      $display("FAIL reset_level: got %0d expected 32", level);
    end
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    measure_window('1, 32, bad, fk, fv);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_first_period: %0d bad cycles, first at cycle %0d got %b", bad, fk, fv);
    end
  endtask

  task automatic test_latency();
    do_reset('1);
    repeat (4) @(negedge clock);
    led_in = 9'h0A5;
    #1;
    tests_run++;
    if (led_out !== 9'h1FF) begin
      tests_failed++;
      $display("FAIL latency_not_combinational: got %h expected 1ff", led_out);
    end
    @(negedge clock);
    tests_run++;
    if (led_out !== 9'h0A5) begin
      tests_failed++;
      $display("FAIL latency_one_cycle_a: got %h expected 0a5", led_out);
    end
    led_in = 9'h15A;
    @(negedge clock);
    tests_run++;
    if (led_out !== 9'h15A) begin
      tests_failed++;
      $display("FAIL latency_one_cycle_b: got %h expected 15a", led_out);
    end
  endtask

  task automatic test_press();
    do_reset('1);
    btn_up = 1'b1;
    repeat (11) @(negedge clock);
    tests_run++;
    if (level !== 8'd32) begin
      tests_failed++;
      $display("FAIL press_too_early: level %0d at cycle 11 expected 32", level);
    end
    @(negedge clock);
    tests_run++;
    if (level !== 8'd48) begin
      tests_failed++;
      $display("FAIL press_latency: level %0d at cycle 12 expected 48", level);
    end
    repeat (8) @(negedge clock);
    btn_up = 1'b0;
    repeat (20) @(negedge clock);
    tests_run++;
    if (level !== 8'd48) begin
      tests_failed++;
      $display("FAIL press_single_step: level %0d expected 48", level);
    end
    btn_down = 1'b1;
    repeat (5) @(negedge clock);
    btn_down = 1'b0;
    repeat (20) @(negedge clock);
    tests_run++;
    if (level !== 8'd48) begin
      tests_failed++;
      $display("FAIL glitch_ignored: level %0d expected 48", level);
    end
  endtask

  task automatic test_saturation();
    int n_on, n_bad;
    do_reset('1);
    repeat (13) press(1'b1, 1'b0);
    tests_run++;
    if (level !== 8'd240) begin
      tests_failed++;
      $display("FAIL sat_reach_240: level %0d expected 240", level);
    end
    press(1'b1, 1'b0);
    tests_run++;
    if (level !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_up_clamp: level %0d expected 255", level);
    end
    press(1'b1, 1'b0);
    tests_run++;
    if (level !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_up_hold: level %0d expected 255", level);
    end
    repeat (300) @(negedge clock);
    count_high('1, n_on, n_bad);
    tests_run++;
    if (n_on != 255 || n_bad != 0) begin
      tests_failed++;
      $display("FAIL duty_255: on=%0d stray=%0d expected on=255 stray=0", n_on, n_bad);
    end
    repeat (15) press(1'b0, 1'b1);
    tests_run++;
    if (level !== 8'd15) begin
      tests_failed++;
      $display("FAIL sat_reach_15: level %0d expected 15", level);
    end
    press(1'b0, 1'b1);
    tests_run++;
    if (level !== 8'd0) begin
      tests_failed++;
      $display("FAIL sat_down_clamp: level %0d expected 0", level);
    end
    press(1'b0, 1'b1);
    tests_run++;
    if (level !== 8'd0) begin
      tests_failed++;
      $display("FAIL sat_down_hold: level %0d expected 0", level);
    end
    repeat (300) @(negedge clock);
    count_high('1, n_on, n_bad);
    tests_run++;
    if (n_on != 0 || n_bad != 0) begin
      tests_failed++;
      $display("FAIL duty_0: on=%0d stray=%0d expected on=0 stray=0", n_on, n_bad);
    end
  endtask

  task automatic test_simultaneous();
    do_reset('1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    tests_run++;
    if (level !== 8'd64) begin
      tests_failed++;
      $display("FAIL simul_setup: level %0d expected 64", level);
    end
    press(1'b1, 1'b1);
    tests_run++;
    if (level !== 8'd64) begin
      tests_failed++;
      $display("FAIL simul_cancel: level %0d expected 64", level);
    end
  endtask

  task automatic test_mid_period();
    int bad, fk;
    logic [CH-1:0] fv;
    logic [CH-1:0] exp;
    do_reset('1);
    bad = 0;
    fk  = 0;
    fv  = '0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clock);
      exp = (k <= 32) ? 9'h1FF : 9'h000;
      if (led_out !== exp) begin
        if (bad == 0) begin
          fk = k;
          fv = led_out;
        end
        bad++;
      end
      if (k == 99) begin
        tests_run++;
        if (level !== 8'd32) begin
          tests_failed++;
          $display("FAIL mid_level_before: level %0d at pwm_cnt 99 expected 32", level);
        end
      end
      if (k == 100) begin
        tests_run++;
        if (level !== 8'd48) begin
          tests_failed++;
          $display("FAIL mid_level_at_100: level %0d expected 48", level);
        end
      end
      if (k == 88) btn_up = 1'b1;
      if (k == 108) btn_up = 1'b0;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mid_current_period: %0d bad cycles, first at cycle %0d got %b", bad, fk, fv);
    end
    measure_window('1, 48, bad, fk, fv);
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL mid_next_period: %0d bad cycles, first at cycle %0d got %b", bad, fk, fv);
    end
  endtask

  task automatic test_async_reset();
    do_reset('1);
    repeat (10) @(negedge clock);
    tests_run++;
    if (led_out !== 9'h1FF) begin
      tests_failed++;
      $display("FAIL async_precondition: led_out %h expected 1ff", led_out);
    end
    reset_ = 1'b0;
    #1;
    tests_run++;
    if (led_out !== 9'h000) begin
      tests_failed++;
      $display("FAIL async_reset_clear: led_out %h expected 000", led_out);
    end
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_gating();
    int n_on, n_bad;
    do_reset(9'b101010101);
    repeat (6) press(1'b1, 1'b0);
    tests_run++;
    if (level !== 8'd128) begin
      tests_failed++;
      $display("FAIL gating_level: level %0d expected 128", level);
    end
    repeat (300) @(negedge clock);
    count_high(9'b101010101, n_on, n_bad);
    tests_run++;
    if (n_on != 128) begin
      tests_failed++;
      $display("FAIL gating_duty: on=%0d expected 128", n_on);
    end
    tests_run++;
    if (n_bad != 0) begin
      tests_failed++;
      $display("FAIL gating_cleared_bits: stray cycles=%0d expected 0", n_bad);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_press();
    test_saturation();
    test_simultaneous();
    test_mid_period();
    test_async_reset();
    test_gating();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
